// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: state encoding, header
// constant for a 256-word load, and the bus widths.
package prog_loader_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned ST_W   = 3;

    // Header byte value that stands for a full 256-word load
    localparam logic [BYTE_W-1:0] HDR_256 = 8'h00;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_WRITE = 3'd4,
        ST_CSUM  = 3'd5,
        ST_DONE  = 3'd6,
        ST_FAIL  = 3'd7
    } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-write output bundle of the program loader.
// master = stream source / processor side, slave = the loader.
interface prog_loader_if;
    import prog_loader_pkg::*;

    logic              start;
    logic [BYTE_W-1:0] byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [WORD_W-1:0] instr_out;
    logic              pr;
    logic [ADDR_W-1:0] waddr;
    logic              cpu_en;
    logic              done;
    logic              err;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, instr_out, pr, waddr, cpu_en, done, err
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, instr_out, pr, waddr, cpu_en, done, err
    );

endinterface

// File: rtl/prog_loader_csum.sv
// Running 8-bit checksum: cleared at load start, accumulates accepted bytes,
// and flags when the sum plus the incoming trailer byte wraps to zero.
module prog_loader_csum
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              add_i,
    input  logic [BYTE_W-1:0] data_i,
    output logic              match_c_o
);

    logic [BYTE_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (add_i) begin
            sum_d = BYTE_W'(sum_q + data_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign match_c_o = (BYTE_W'(sum_q + data_i) == '0);

endmodule

// File: rtl/prog_loader.sv
// Program loader: takes a word-count header then hi/lo byte pairs and strobes each
// word into instruction memory. Optional checksum trailer: PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    inout  wire          dvdd,
    inout  wire          dgnd,
    prog_loader_if.slave bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] last_addr_c;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic              byte_ready_q, byte_ready_d;
    logic              pr_q, pr_d;
    logic              done_q, done_d;
    logic              accept_c;

    // Power pins are feed-through only
    wire unused_pwr;
    assign unused_pwr = &{1'b0, dvdd, dgnd};

    assign accept_c    = bus.byte_valid && byte_ready_q;
    assign last_addr_c = (count_q == HDR_256) ? ADDR_W'(8'hFF) : ADDR_W'(count_q - ADDR_W'(1));

`ifdef PROG_LOADER_CHECKSUM_EN
    logic err_q, err_d;
    logic csum_clr_c, csum_add_c, csum_ok_c;

    assign csum_clr_c = bus.start && (state_q inside {ST_IDLE, ST_DONE, ST_FAIL});
    assign csum_add_c = accept_c && (state_q inside {ST_HDR, ST_HI, ST_LO});

    prog_loader_csum u_csum (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (csum_clr_c),
        .add_i     (csum_add_c),
        .data_i    (bus.byte_in),
        .match_c_o (csum_ok_c)
    );
`endif

    // Next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        waddr_d = waddr_q;
        instr_d = instr_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (bus.start) begin
                    state_d = ST_HDR;
                    waddr_d = '0;
                end
            end
            ST_HDR: begin
                if (accept_c) begin
                    count_d = bus.byte_in;
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                if (accept_c) begin
                    instr_d[WORD_W-1 -: BYTE_W] = bus.byte_in;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (accept_c) begin
                    instr_d[BYTE_W-1:0] = bus.byte_in;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (waddr_q == last_addr_c) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    waddr_d = ADDR_W'(waddr_q + ADDR_W'(1));
                    state_d = ST_HI;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (accept_c) begin
                    state_d = csum_ok_c ? ST_DONE : ST_FAIL;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        byte_ready_d = state_d inside {ST_HDR, ST_HI, ST_LO, ST_CSUM};
        pr_d         = (state_d == ST_WRITE);
        done_d       = (state_d == ST_DONE);
`ifdef PROG_LOADER_CHECKSUM_EN
        err_d        = (state_d == ST_FAIL);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            waddr_q      <= '0;
            instr_q      <= '0;
            byte_ready_q <= 1'b0;
            pr_q         <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            waddr_q      <= waddr_d;
            instr_q      <= instr_d;
            byte_ready_q <= byte_ready_d;
            pr_q         <= pr_d;
            done_q       <= done_d;
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.byte_ready = byte_ready_q;
    assign bus.instr_out  = instr_q;
    assign bus.pr         = pr_q;
    assign bus.waddr      = waddr_q;
    assign bus.cpu_en     = done_q;
    assign bus.done       = done_q;

endmodule
